booth_seq_mult: RTL

//  Multi-cycle radix-4 Booth multiplier with a carry-save accumulator, a parametrised successor to the 8x8 four-row PP compressor.

---
 rtl/booth_seq_mult.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: multi-cycle radix-4 Booth multiplier with a carry-save
// accumulator. Each ACC cycle folds PP_PER_CYC Booth partial products into a
// running sum/carry pair. One final add cycle resolves the 2*WIDTH-bit product.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid and
// out_p hold steady in DONE until the edge that sees out_ready high.
module booth_seq_mult #(
  parameter int WIDTH      = 8,
  parameter int PP_PER_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int ITER = (NDIG + PP_PER_CYC - 1) / PP_PER_CYC;
  localparam int CW   = $clog2(ITER);
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH+1:0] b_q, b_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [PW-1:0]    out_p_q, out_p_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH+2:0] b_pad;
  logic [PW-1:0]    cmp_sum, cmp_carry, pp_row, inj_row;
  logic [2:0]       trip;
  int               dig_idx;

  // Booth digit times A, sign-extended to PW bits; inverted for negative
  // digits (the matching +1 goes into the injection row).
  function automatic logic [PW-1:0] booth_row(input logic [WIDTH:0] a,
                                              input logic [2:0]   t);
    logic [WIDTH+1:0] m;
    logic [PW-1:0]    mx;
    case (t)
      3'b001, 3'b010, 3'b101, 3'b110: m = {a[WIDTH], a};
      3'b011, 3'b100:                 m = {a, 1'b0};
      default:                        m = '0;
    endcase
    mx = {{(PW-WIDTH-2){m[WIDTH+1]}}, m};
    if (t[2] && !(t[1] && t[0])) mx = ~mx;
    return mx;
  endfunction

  // 3:2 carry-save stage; carry shifted left, bit out of the MSB dropped.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                          input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
    logic [PW-1:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  // B[-1] = 0 is appended below the extended multiplier.
  assign b_pad = {b_q, 1'b0};

  // Fold this cycle's Booth rows plus their +1 injections into sum/carry.
  // Chained 3:2 stages form the 4:2 row (or a plain 3:2 row at one digit).
  always_comb begin
    cmp_sum   = sum_q;
    cmp_carry = carry_q;
    inj_row   = '0;
    pp_row    = '0;
    trip      = '0;
    dig_idx   = 0;
    for (int p = 0; p < PP_PER_CYC; p++) begin
      dig_idx = int'(cnt_q) * PP_PER_CYC + p;
      if (dig_idx < NDIG) begin
        trip   = b_pad[2*dig_idx +: 3];
        pp_row = booth_row(a_q, trip) << (2 * dig_idx);
        if (trip[2] && !(trip[1] && trip[0]))
          inj_row = inj_row | (PW'(1) << (2 * dig_idx));
      end else begin
        pp_row = '0;
      end
      {cmp_sum, cmp_carry} = csa(cmp_sum, cmp_carry, pp_row);
    end
    {cmp_sum, cmp_carry} = csa(cmp_sum, cmp_carry, inj_row);
  end

  // Next-state and datapath updates for IDLE -> ACC -> ADD -> DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = {in_signed & in_a[WIDTH-1], in_a};
          b_d     = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        sum_d   = cmp_sum;
        carry_d = cmp_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_ADD;
      end
      S_ADD: begin
        out_p_d     = sum_q + carry_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule
